// File: rtl/test_i2540_pkg.sv
// Shared types and constants for the 1011 serial pattern detector with sticky alarm.
package test_i2540_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S10  = 2'd2,
        S101 = 2'd3
    } det_state_e;

    // Oldest bit first: PATTERN[3] arrives first, PATTERN[0] completes the match.
    localparam logic [3:0] PATTERN         = 4'b1011;
    localparam int         ALARM_THRESHOLD = 4;
    localparam int         CNT_W           = 3;

    localparam logic [CNT_W-1:0] ALARM_LIMIT = CNT_W'(ALARM_THRESHOLD);

endpackage

// File: rtl/i2540_seq_det.sv
// Mealy FSM recognising the serial pattern 1011 with overlap; detect is combinational.
module i2540_seq_det
    import test_i2540_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic n,
    output logic detect
);

    det_state_e state_q, state_d;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        detect  = 1'b0;
        case (state_q)
            IDLE: state_d = n ? S1 : IDLE;
            S1:   state_d = n ? S1 : S10;
            S10:  state_d = n ? S101 : IDLE;
            S101: begin
                if (n == PATTERN[0]) begin
                    state_d = S1;
                    detect  = 1'b1;
                end else begin
                    state_d = S10;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/test_i2540.sv
// Top level: pattern detector, saturating detection counter, one-cycle pulse and sticky alarm.
module test_i2540
    import test_i2540_pkg::*;
(
    input  logic N,
    input  logic CK,
    input  logic reset,
    output logic output_single
);

    logic             detect;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             det_q, det_d;
    logic             alarm_q, alarm_d;

    i2540_seq_det u_seq_det (
        .clk    (CK),
        .rst    (reset),
        .n      (N),
        .detect (detect)
    );

    always_comb begin
        det_d = detect;
        cnt_d = cnt_q;
        if (detect && (cnt_q != ALARM_LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // The alarm rises on the same edge the counter lands on the threshold.
        alarm_d = alarm_q | (cnt_d == ALARM_LIMIT);
    end

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            det_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            det_q   <= det_d;
            alarm_q <= alarm_d;
        end
    end

    assign output_single = det_q | alarm_q;

endmodule

// File: tb/tb_test_i2540.sv
// Scoreboard bench for test_i2540: stimulus queues expected outputs, a monitor checks each edge.
module tb_test_i2540;

    logic N;
    logic CK;
    logic reset;
    logic output_single;

    int tests_run = 0;
    int tests_failed = 0;

    bit    exp_q[$];
    string name_q[$];

    test_i2540 dut (
        .N             (N),
        .CK            (CK),
        .reset         (reset),
        .output_single (output_single)
    );

    initial CK = 1'b0;
    always #10 CK = ~CK;

    task automatic check(input string name, input logic actual, input logic expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: output_single=%b, expected %b at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Drive one serial bit for the next rising edge and queue the output expected after it.
    task automatic step(input logic val, input bit expected, input string name);
        N = val;
        exp_q.push_back(expected);
        name_q.push_back(name);
        @(posedge CK);
        #2;
    endtask

    // Reset pulse placed between edges; output must clear before any clock edge.
    task automatic pulse_reset(input string name);
        reset = 1'b1;
        #1;
        check(name, output_single, 1'b0);
        #3;
        reset = 1'b0;
        #1;
    endtask

    // Monitor: one queued expectation is consumed per rising edge, sampled 1 ns after it.
    initial begin
        forever begin
            @(posedge CK);
            #1;
            if (exp_q.size() > 0) begin
                check(name_q.pop_front(), output_single, exp_q.pop_front());
            end
        end
    end

    initial begin
        N     = 1'b0;
        reset = 1'b1;
        #2;
        check("reset_state", output_single, 1'b0);
        #3;
        reset = 1'b0;
        #1;

        // First edges after reset: N=0 then N=1, no output
        step(1'b0, 1'b0, "first_edge_n0");
        step(1'b1, 1'b0, "second_edge_n1");

        // Single pattern 1,0,1,1,0
        pulse_reset("rst_before_single");
        step(1'b1, 1'b0, "single_e1");
        step(1'b0, 1'b0, "single_e2");
        step(1'b1, 1'b0, "single_e3");
        step(1'b1, 1'b1, "single_e4_detect");
        step(1'b0, 1'b0, "single_e5_pulse_end");

        // Overlap: 1,0,1,1,0,1,1 -> pulses at edges 4 and 7
        pulse_reset("rst_before_overlap");
        step(1'b1, 1'b0, "ovl_e1");
        step(1'b0, 1'b0, "ovl_e2");
        step(1'b1, 1'b0, "ovl_e3");
        step(1'b1, 1'b1, "ovl_e4_detect");
        step(1'b0, 1'b0, "ovl_e5");
        step(1'b1, 1'b0, "ovl_e6");
        step(1'b1, 1'b1, "ovl_e7_detect");

        // Alarm: detections at 4,7,10,13; alarm sticks from edge 13
        pulse_reset("rst_before_alarm");
        step(1'b1, 1'b0, "alm_e1");
        step(1'b0, 1'b0, "alm_e2");
        step(1'b1, 1'b0, "alm_e3");
        step(1'b1, 1'b1, "alm_e4_det1");
        step(1'b0, 1'b0, "alm_e5");
        step(1'b1, 1'b0, "alm_e6");
        step(1'b1, 1'b1, "alm_e7_det2");
        step(1'b0, 1'b0, "alm_e8");
        step(1'b1, 1'b0, "alm_e9");
        step(1'b1, 1'b1, "alm_e10_det3");
        step(1'b0, 1'b0, "alm_e11");
        step(1'b1, 1'b0, "alm_e12");
        step(1'b1, 1'b1, "alm_e13_det4_alarm");
        step(1'b0, 1'b1, "alm_e14_sticky");
        step(1'b0, 1'b1, "alm_e15_sticky");

        // Further detection while alarmed keeps output high
        step(1'b1, 1'b1, "alm_more_e1");
        step(1'b0, 1'b1, "alm_more_e2");
        step(1'b1, 1'b1, "alm_more_e3");
        step(1'b1, 1'b1, "alm_more_e4_det");
        step(1'b0, 1'b1, "alm_more_e5");

        // Reset after alarm clears everything immediately
        pulse_reset("rst_after_alarm_async");
        step(1'b0, 1'b0, "post_alarm_n0_a");
        step(1'b0, 1'b0, "post_alarm_n0_b");

        // Counter must be cleared too: one detection gives only a pulse
        step(1'b1, 1'b0, "cnt_clr_e1");
        step(1'b0, 1'b0, "cnt_clr_e2");
        step(1'b1, 1'b0, "cnt_clr_e3");
        step(1'b1, 1'b1, "cnt_clr_e4_detect");
        step(1'b0, 1'b0, "cnt_clr_e5_no_alarm");

        // Reset mid-pattern discards partial history
        pulse_reset("rst_before_mid");
        step(1'b1, 1'b0, "mid_e1");
        step(1'b0, 1'b0, "mid_e2");
        step(1'b1, 1'b0, "mid_e3");
        pulse_reset("rst_mid_pattern");
        step(1'b1, 1'b0, "mid_after_rst_n1");
        step(1'b0, 1'b0, "mid_after_rst_n0");

        // Bounded drain of the scoreboard
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge CK);
            #2;
        end
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
